// File: rtl/carry_save_final_sum.sv
// Two-stage three-operand adder: a 3:2 carry-save stage, then a carry-propagate stage.
// Optional macro CSA_OVF_EN adds a registered ovf output (carry-out of the final add).
module carry_save_final_sum #(
   parameter int N = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         in_valid,
   input  logic [N-1:0] A,
   input  logic [N-1:0] B,
   input  logic [N-1:0] C,
   output logic [N-1:0] Sum,
   output logic [N-1:0] Carry,
   output logic         mid_valid,
   output logic [N:0]   Final_Sum,
`ifdef CSA_OVF_EN
   output logic         ovf,
`endif
   output logic         out_valid
);

   function automatic logic [N-1:0] csa_sum(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] c);
      return a ^ b ^ c;
   endfunction

   function automatic logic [N-1:0] csa_maj(input logic [N-1:0] a, input logic [N-1:0] b,
                                            input logic [N-1:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   logic [N-1:0] r_sum;
   logic [N-1:0] r_carry;
   logic         r_mid_valid;
   logic [N:0]   r_final;
   logic         r_out_valid;
   logic         r_ovf;
   logic [N+1:0] w_cpa;

   // Carry is stored unshifted, so it enters the final add one place to the left.
   assign w_cpa = {2'b00, r_sum} + {1'b0, r_carry, 1'b0};

   // Carry-save stage: captures every cycle, valid only qualifies the data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sum       <= {N{1'b0}};
         r_carry     <= {N{1'b0}};
         r_mid_valid <= 1'b0;
      end else begin
         r_sum       <= csa_sum(A, B, C);
         r_carry     <= csa_maj(A, B, C);
         r_mid_valid <= in_valid;
      end
   end

   // Carry-propagate stage: result wraps modulo 2^(N+1), bit N+1 is the overflow.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_final     <= {(N+1){1'b0}};
         r_ovf       <= 1'b0;
         r_out_valid <= 1'b0;
      end else begin
         r_final     <= w_cpa[N:0];
         r_ovf       <= w_cpa[N+1];
         r_out_valid <= r_mid_valid;
      end
   end

   assign Sum       = r_sum;
   assign Carry     = r_carry;
   assign mid_valid = r_mid_valid;
   assign Final_Sum = r_final;
   assign out_valid = r_out_valid;
`ifdef CSA_OVF_EN
   assign ovf       = r_ovf;
`else
   logic w_unused_ovf;
   assign w_unused_ovf = r_ovf;
`endif

endmodule

// File: tb/tb_carry_save_final_sum.sv
// Scoreboard bench for carry_save_final_sum (N=8); checks ovf when CSA_OVF_EN is defined.
module tb_carry_save_final_sum;
   localparam int N = 8;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic [N-1:0] A, B, C;
   logic [N-1:0] Sum, Carry;
   logic         mid_valid, out_valid;
   logic [N:0]   Final_Sum;
`ifdef CSA_OVF_EN
   logic         ovf;
`endif

   carry_save_final_sum #(.N(N)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
      .A(A), .B(B), .C(C),
      .Sum(Sum), .Carry(Carry), .mid_valid(mid_valid),
      .Final_Sum(Final_Sum),
`ifdef CSA_OVF_EN
      .ovf(ovf),
`endif
      .out_valid(out_valid)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [N-1:0] s; logic [N-1:0] c; } mid_t;
   typedef struct { logic [N:0] f; logic o; } out_t;

   mid_t mid_q[$];
   out_t out_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   logic exp_mid_v = 1'b0;
   logic exp_out_v = 1'b0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference built from per-bit ones count and a wide integer sum.
   task automatic drive(input logic [N-1:0] a, input logic [N-1:0] b, input logic [N-1:0] c);
      mid_t m;
      out_t o;
      int   cnt;
      int   total;
      for (int i = 0; i < N; i++) begin
         cnt = int'(a[i]) + int'(b[i]) + int'(c[i]);
         m.s[i] = (cnt % 2) == 1;
         m.c[i] = cnt >= 2;
      end
      total = int'(a) + int'(b) + int'(c);
      o.f = N'(0) + (N+1)'(total % (1 << (N+1)));
      o.o = total >= (1 << (N+1));
      mid_q.push_back(m);
      out_q.push_back(o);
      in_valid = 1'b1;
      A = a; B = b; C = c;
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic tick();
      mid_t m;
      out_t o;
      @(posedge clk);
      #1;
      exp_out_v = exp_mid_v;
      exp_mid_v = in_valid;
      check("mid_valid", 32'(mid_valid), 32'(exp_mid_v));
      if (exp_mid_v) begin
         if (mid_q.size() == 0) check("mid_q_underflow", 32'd1, 32'd0);
         else begin
            m = mid_q.pop_front();
            check("Sum", 32'(Sum), 32'(m.s));
            check("Carry", 32'(Carry), 32'(m.c));
         end
      end
      check("out_valid", 32'(out_valid), 32'(exp_out_v));
      if (exp_out_v) begin
         if (out_q.size() == 0) check("out_q_underflow", 32'd1, 32'd0);
         else begin
            o = out_q.pop_front();
            check("Final_Sum", 32'(Final_Sum), 32'(o.f));
`ifdef CSA_OVF_EN
            check("ovf", 32'(ovf), 32'(o.o));
`endif
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_Sum"}, 32'(Sum), 32'd0);
      check({tag, "_Carry"}, 32'(Carry), 32'd0);
      check({tag, "_Final_Sum"}, 32'(Final_Sum), 32'd0);
      check({tag, "_mid_valid"}, 32'(mid_valid), 32'd0);
      check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
`ifdef CSA_OVF_EN
      check({tag, "_ovf"}, 32'(ovf), 32'd0);
`endif
   endtask

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0;
      A = 8'd0; B = 8'd0; C = 8'd0;
      #12;
      check_all_zero("reset");
      rst_n = 1'b1;

      // Directed test-plan vectors, streamed back to back.
      drive(8'd13, 8'd7, 8'd3);     tick();
      drive(8'd9, 8'd6, 8'd5);      tick();
      drive(8'd240, 8'd15, 8'd1);   tick();
      drive(8'd255, 8'd255, 8'd255); tick();
      drive(8'd1, 8'd1, 8'd1);      tick();
      drive(8'd0, 8'd0, 8'd0);      tick();
      idle();                       tick();
      idle();                       tick();
      idle();                       tick();

      // Random back-to-back burst with a bubble in the middle.
      for (int k = 0; k < 12; k++) begin
         if (k == 6) idle();
         else drive(N'($urandom_range(255)), N'($urandom_range(255)), N'($urandom_range(255)));
         tick();
      end
      idle(); tick();
      idle(); tick();
      idle(); tick();

      // Asynchronous reset while two operations are in flight.
      drive(8'd200, 8'd100, 8'd50); tick();
      drive(8'd77, 8'd88, 8'd99);   tick();
      #3;
      rst_n = 1'b0;
      #1;
      check_all_zero("async_rst");
      in_valid = 1'b0;
      A = 8'd0; B = 8'd0; C = 8'd0;
      mid_q.delete();
      out_q.delete();
      exp_mid_v = 1'b0;
      exp_out_v = 1'b0;
      @(posedge clk);
      #2;
      check_all_zero("rst_held");
      rst_n = 1'b1;
      tick();
      tick();
      check_all_zero("post_rst");

      drive(8'd128, 8'd128, 8'd128); tick();
      drive(8'd3, 8'd5, 8'd6);       tick();
      idle(); tick();
      idle(); tick();
      idle(); tick();

      check("scoreboard_drained", 32'(mid_q.size() + out_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
